// File: rtl/mips16_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips16_multicycle_ctrl
//
// Multicycle control FSM for the 16-bit MIPS core. Steps every instruction
// through FETCH / DECODE / EXEC / MEM / WB and drives the datapath strobes.
// It also provides a memory-wait timeout, a retired-instruction counter
// and a terminal HALT state.
//
// Parameters
//   TIMEOUT_CYCLES  max mem_ready wait cycles per request (0 = never time out)
//   CNT_W           width of the retired-instruction counter
//
// Optional feature
//   ILLEGAL_TRAP_EN  when defined, opcodes 1000-1111 halt the core and set
//                    'illegal'. When undefined they retire as NOPs and
//                    'illegal' is tied low.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   run         in   1 = allow a new fetch (only looked at in FETCH)
//   opcode      in   decoder opcode instr[15:12], valid in DECODE
//   mem_ready   in   memory completes the current request this cycle
//   mem_req     out  memory request (instruction fetch or data access)
//   mem_we      out  data write (SW in MEM)
//   ir_we       out  load instruction register
//   pc_we       out  update PC
//   pc_src      out  0 = PC+1, 1 = jump target
//   alu_src_b   out  0 = rt, 1 = zero-extended imm[3:0]
//   alu_op      out  00 ADD, 01 SUB, 10 XOR, 11 OR
//   reg_we      out  register-file write of rd
//   mem_to_reg  out  1 = write-back data from memory, 0 = ALU result
//   halted      out  FSM sits in HALT
//   bus_err     out  sticky, halted by a memory timeout
//   illegal     out  sticky, halted by an illegal opcode
//   retired     out  count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module mips16_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  // Opcode map
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0011;
  localparam logic [3:0] OP_SW   = 4'b0100;
  localparam logic [3:0] OP_JUMP = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // The wait counter only ever has to hold 0 .. TIMEOUT_CYCLES-1: reaching
  // the last value without a grant ends in HALT.
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        op_reg;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]  retired_reg;
  logic              bus_err_reg;
  logic              retire_inc;
  logic              set_bus_err;
  logic              wait_expired;
  logic [1:0]        alu_op_dec;
  logic              alu_src_b_dec;
`ifdef ILLEGAL_TRAP_EN
  logic              illegal_reg;
  logic              set_illegal;
`endif

  // True on the final allowed wait cycle of a request; if mem_ready is
  // still low in that cycle the request is abandoned.
  assign wait_expired = TIMEOUT_EN && (wait_cnt_reg == WAIT_LAST);

  // ALU controls for the latched opcode. Used in EXEC and held through WB
  // so the ALU result stays stable while the register file writes it.
  always_comb begin
    alu_op_dec    = ALU_ADD;
    alu_src_b_dec = 1'b0;
    case (op_reg)
      OP_SUB:                alu_op_dec    = ALU_SUB;
      OP_XOR:                alu_op_dec    = ALU_XOR;
      OP_OR:                 alu_op_dec    = ALU_OR;
      OP_ADDI, OP_LW, OP_SW: alu_src_b_dec = 1'b1;
      default:               alu_op_dec    = ALU_ADD;
    endcase
  end

  // Next-state and strobe logic
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    retire_inc    = 1'b0;
    set_bus_err   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    set_illegal   = 1'b0;
`endif
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_src        = 1'b0;
    alu_src_b     = 1'b0;
    alu_op        = ALU_ADD;
    reg_we        = 1'b0;
    mem_to_reg    = 1'b0;
    halted        = 1'b0;

    // While reset is held the state already reads FETCH, but no request
    // may escape until reset is released.
    if (!reset) begin
      case (state_reg)
        ST_FETCH: begin
          mem_req = run;
          if (run && mem_ready) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            state_next = ST_DECODE;
          end else if (run && wait_expired) begin
            state_next  = ST_HALT;
            set_bus_err = 1'b1;
          end
        end

        // op_reg is not loaded yet, so DECODE works on the live opcode.
        ST_DECODE: begin
          case (opcode)
            OP_JUMP: begin
              pc_we      = 1'b1;
              pc_src     = 1'b1;
              retire_inc = 1'b1;
              state_next = ST_FETCH;
            end
            OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW, OP_XOR, OP_OR: begin
              state_next = ST_EXEC;
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state_next  = ST_HALT;
              set_illegal = 1'b1;
`else
              retire_inc  = 1'b1;
              state_next  = ST_FETCH;
`endif
            end
          endcase
        end

        ST_EXEC: begin
          alu_op    = alu_op_dec;
          alu_src_b = alu_src_b_dec;
          if (op_reg == OP_LW || op_reg == OP_SW) begin
            state_next = ST_MEM;
          end else begin
            state_next = ST_WB;
          end
        end

        // The address (base + imm) is held on the ALU for the whole access.
        ST_MEM: begin
          mem_req   = 1'b1;
          mem_we    = (op_reg == OP_SW);
          alu_op    = ALU_ADD;
          alu_src_b = 1'b1;
          if (mem_ready) begin
            if (op_reg == OP_SW) begin
              retire_inc = 1'b1;
              state_next = ST_FETCH;
            end else begin
              state_next = ST_WB;
            end
          end else if (wait_expired) begin
            state_next  = ST_HALT;
            set_bus_err = 1'b1;
          end
        end

        ST_WB: begin
          reg_we     = 1'b1;
          mem_to_reg = (op_reg == OP_LW);
          alu_op     = alu_op_dec;
          alu_src_b  = alu_src_b_dec;
          retire_inc = 1'b1;
          state_next = ST_FETCH;
        end

        ST_HALT: begin
          halted = 1'b1;
        end

        default: begin
          state_next = ST_HALT;
        end
      endcase

      // Wait counting is per request: any grant or state change restarts it.
      // With run low in FETCH there is no request and the count is kept.
      if (state_next != state_reg) begin
        wait_cnt_next = '0;
      end else if (mem_req && mem_ready) begin
        wait_cnt_next = '0;
      end else if (mem_req) begin
        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_FETCH;
      op_reg       <= '0;
      wait_cnt_reg <= '0;
      retired_reg  <= '0;
      bus_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == ST_DECODE) begin
        op_reg <= opcode;
      end
      if (retire_inc) begin
        retired_reg <= retired_reg + CNT_W'(1);
      end
      if (set_bus_err) begin
        bus_err_reg <= 1'b1;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_reg <= 1'b0;
    end else if (set_illegal) begin
      illegal_reg <= 1'b1;
    end
  end

  assign illegal = illegal_reg;
`else
  assign illegal = 1'b0;
`endif

  assign bus_err = bus_err_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_mips16_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips16_multicycle_ctrl
//
// Self-checking bench for mips16_multicycle_ctrl (TIMEOUT_CYCLES=4, CNT_W=4).
// For every instruction the bench writes out the expected per-cycle strobe
// pattern from the instruction-level rules (fetch waits, decode, exec,
// memory waits, write-back), then plays it against the DUT with randomized
// don't-care inputs. The retired count is kept as a plain integer.
// ---------------------------------------------------------------------------
module tb_mips16_multicycle_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [3:0]    opcode;
  logic          mem_ready;
  logic          mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_b;
  logic [1:0]    alu_op;
  logic          reg_we, mem_to_reg, halted, bus_err, illegal;
  logic [CW-1:0] retired;

  mips16_multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
    .halted(halted), .bus_err(bus_err), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // One expected cycle: inputs to drive and the strobes that must appear.
  typedef struct {
    logic       run;
    logic       rdy;
    logic [3:0] op;
    logic [12:0] exp;
    logic       inc;
  } row_t;

  row_t          rows[$];
  int            ret_model;
  int            errors = 0;
  int            checks = 0;
  logic [12:0]   obs;
  logic [CW-1:0] ret_obs;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  // {mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_b, alu_op, reg_we,
  //  mem_to_reg, halted, bus_err, illegal}
  function automatic logic [12:0] mk(input logic req, input logic we,
      input logic irw, input logic pcw, input logic pcs, input logic srcb,
      input logic [1:0] aop, input logic rw, input logic m2r,
      input logic hlt, input logic be, input logic il);
    return {req, we, irw, pcw, pcs, srcb, aop, rw, m2r, hlt, be, il};
  endfunction

  // {alu_src_b, alu_op} required by the instruction table
  function automatic logic [2:0] alu_ref(input logic [3:0] op);
    case (op)
      4'd1:             return 3'b001;
      4'd6:             return 3'b010;
      4'd7:             return 3'b011;
      4'd2, 4'd3, 4'd4: return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction

  task automatic add(input logic r, input logic rd, input logic [3:0] op,
                     input logic [12:0] e, input logic inc);
    row_t x;
    x.run = r; x.rdy = rd; x.op = op; x.exp = e; x.inc = inc;
    rows.push_back(x);
  endtask

  task automatic add_halt(input int n, input logic be, input logic il);
    for (int i = 0; i < n; i++)
      add(rb(), rb(), rop(), mk(0,0,0,0,0,0,2'b00,0,0,1,be,il), 1'b0);
  endtask

  // n request cycles with mem_ready low; the TO-th one ends the request
  task automatic add_waits(input int n, input bit is_mem, input bit is_sw,
                           output bit timed_out);
    timed_out = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (is_mem)
        add(rb(), 1'b0, rop(), mk(1,is_sw,0,0,0,1,2'b00,0,0,0,0,0), 1'b0);
      else
        add(1'b1, 1'b0, rop(), mk(1,0,0,0,0,0,2'b00,0,0,0,0,0), 1'b0);
      if (i == TO - 1) begin
        timed_out = 1'b1;
        return;
      end
    end
  endtask

  bit halts;

  // Expected cycle list for one instruction:
  // idle = FETCH cycles with run low, fw/mw = fetch/data wait cycles,
  // nh = cycles to observe in HALT if the instruction halts.
  task automatic build(input logic [3:0] op, input int idle, input int fw,
                       input int mw, input int nh);
    bit to;
    logic [2:0] a;
    rows.delete();
    halts = 1'b0;
    for (int i = 0; i < idle; i++)
      add(1'b0, rb(), rop(), mk(0,0,0,0,0,0,2'b00,0,0,0,0,0), 1'b0);
    add_waits(fw, 1'b0, 1'b0, to);
    if (to) begin
      halts = 1'b1;
      add_halt(nh, 1'b1, 1'b0);
      return;
    end
    add(1'b1, 1'b1, rop(), mk(1,0,1,1,0,0,2'b00,0,0,0,0,0), 1'b0);
    if (op == 4'd5) begin
      add(rb(), rb(), op, mk(0,0,0,1,1,0,2'b00,0,0,0,0,0), 1'b1);
      return;
    end
    if (op[3]) begin
`ifdef ILLEGAL_TRAP_EN
      add(rb(), rb(), op, 13'd0, 1'b0);
      halts = 1'b1;
      add_halt(nh, 1'b0, 1'b1);
`else
      add(rb(), rb(), op, 13'd0, 1'b1);
`endif
      return;
    end
    add(rb(), rb(), op, 13'd0, 1'b0);
    a = alu_ref(op);
    add(rb(), rb(), rop(), mk(0,0,0,0,0,a[2],a[1:0],0,0,0,0,0), 1'b0);
    if (op == 4'd3 || op == 4'd4) begin
      add_waits(mw, 1'b1, op == 4'd4, to);
      if (to) begin
        halts = 1'b1;
        add_halt(nh, 1'b1, 1'b0);
        return;
      end
      add(rb(), 1'b1, rop(), mk(1,op==4'd4,0,0,0,1,2'b00,0,0,0,0,0), op == 4'd4);
      if (op == 4'd4) return;
    end
    add(rb(), rb(), rop(), mk(0,0,0,0,0,a[2],a[1:0],1,op==4'd3,0,0,0), 1'b1);
  endtask

  // Drive one row's inputs (called just after a falling edge) and sample.
  task automatic apply(input row_t r);
    run = r.run; mem_ready = r.rdy; opcode = r.op;
    #1;
    obs = {mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_b, alu_op,
           reg_we, mem_to_reg, halted, bus_err, illegal};
    ret_obs = retired;
  endtask

  task automatic advance(input row_t r);
    @(posedge clk);
    if (r.inc) ret_model++;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ret_model = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; mem_ready = 1'b1; opcode = rop();
    #1;
    obs = {mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_b, alu_op,
           reg_we, mem_to_reg, halted, bus_err, illegal};
    checks++;
    if (obs !== 13'd0) begin
      errors++; $display("FAIL reset_strobes got %b need %b", obs, 13'd0);
    end
    checks++;
    if (retired !== '0) begin
      errors++; $display("FAIL reset_retired got %0d need 0", retired);
    end
    @(negedge clk);
    reset = 1'b0; ret_model = 0; mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || ir_we !== 1'b0) begin
      errors++; $display("FAIL reset_fetch mem_req=%b ir_we=%b need 1 0", mem_req, ir_we);
    end
    $display("test_reset done");
  endtask

  task automatic test_alu();
    reset_dut();
    build(4'd0, 0, 0, 0, 0);
    foreach (rows[i]) begin
      apply(rows[i]);
      checks++;
      if (obs !== rows[i].exp) begin
        errors++; $display("FAIL alu row %0d got %b need %b", i, obs, rows[i].exp);
      end
      checks++;
      if (ret_obs !== CW'(ret_model)) begin
        errors++; $display("FAIL alu_ret row %0d got %0d need %0d", i, ret_obs, CW'(ret_model));
      end
      advance(rows[i]);
    end
    #1;
    checks++;
    if (retired !== CW'(1)) begin
      errors++; $display("FAIL alu_retired got %0d need 1", retired);
    end
    $display("test_alu: ADD r1=r2+r3 rows=%0d", rows.size());
  endtask

  task automatic test_lw_wait();
    int req_cycles = 0;
    reset_dut();
    build(4'd3, 0, 0, 3, 0);
    foreach (rows[i]) begin
      apply(rows[i]);
      if (i >= 3 && mem_req === 1'b1) req_cycles++;
      checks++;
      if (obs !== rows[i].exp) begin
        errors++; $display("FAIL lw row %0d got %b need %b", i, obs, rows[i].exp);
      end
      checks++;
      if (ret_obs !== CW'(ret_model)) begin
        errors++; $display("FAIL lw_ret row %0d got %0d need %0d", i, ret_obs, CW'(ret_model));
      end
      advance(rows[i]);
    end
    #1;
    checks++;
    if (req_cycles != 4 || retired !== CW'(1)) begin
      errors++; $display("FAIL lw_summary req_cycles=%0d retired=%0d need 4 1", req_cycles, retired);
    end
    $display("test_lw_wait: LW with 3 wait cycles");
  endtask

  task automatic test_jump();
    reset_dut();
    for (int k = 0; k < 2; k++) begin
      build((k == 0) ? 4'd5 : 4'd1, 0, 0, 0, 0);
      foreach (rows[i]) begin
        apply(rows[i]);
        checks++;
        if (obs !== rows[i].exp) begin
          errors++; $display("FAIL jump instr %0d row %0d got %b need %b", k, i, obs, rows[i].exp);
        end
        checks++;
        if (ret_obs !== CW'(ret_model)) begin
          errors++; $display("FAIL jump_ret row %0d got %0d need %0d", i, ret_obs, CW'(ret_model));
        end
        advance(rows[i]);
      end
    end
    $display("test_jump: JUMP then SUB, retired=%0d", ret_model);
  endtask

  task automatic test_timeout();
    reset_dut();
    build(4'd0, 0, 4, 0, 4);
    foreach (rows[i]) begin
      apply(rows[i]);
      checks++;
      if (obs !== rows[i].exp) begin
        errors++; $display("FAIL timeout row %0d got %b need %b", i, obs, rows[i].exp);
      end
      advance(rows[i]);
    end
    // a data-side timeout on a store
    reset_dut();
    build(4'd4, 0, 0, 4, 2);
    foreach (rows[i]) begin
      apply(rows[i]);
      checks++;
      if (obs !== rows[i].exp) begin
        errors++; $display("FAIL timeout_mem row %0d got %b need %b", i, obs, rows[i].exp);
      end
      checks++;
      if (ret_obs !== CW'(ret_model)) begin
        errors++; $display("FAIL timeout_ret row %0d got %0d need %0d", i, ret_obs, CW'(ret_model));
      end
      advance(rows[i]);
    end
    reset_dut();
    #1;
    checks++;
    if (halted !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL timeout_clear halted=%b bus_err=%b need 0 0", halted, bus_err);
    end
    @(negedge clk);
    $display("test_timeout: fetch and store timeouts");
  endtask

  task automatic test_illegal();
    reset_dut();
    build(4'd5, 0, 0, 0, 0);
    foreach (rows[i]) begin
      apply(rows[i]);
      advance(rows[i]);
    end
    build(4'd9, 0, 0, 0, 3);
    foreach (rows[i]) begin
      apply(rows[i]);
      checks++;
      if (obs !== rows[i].exp) begin
        errors++; $display("FAIL illegal row %0d got %b need %b", i, obs, rows[i].exp);
      end
      advance(rows[i]);
    end
    #1;
    checks++;
`ifdef ILLEGAL_TRAP_EN
    if (halted !== 1'b1 || illegal !== 1'b1 || retired !== CW'(1)) begin
      errors++; $display("FAIL illegal_trap halted=%b illegal=%b retired=%0d need 1 1 1", halted, illegal, retired);
    end
`else
    if (halted !== 1'b0 || illegal !== 1'b0 || retired !== CW'(2)) begin
      errors++; $display("FAIL illegal_nop halted=%b illegal=%b retired=%0d need 0 0 2", halted, illegal, retired);
    end
`endif
    @(negedge clk);
    $display("test_illegal: opcode 1001");
  endtask

  task automatic test_wrap();
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      build(4'd5, 0, 0, 0, 0);
      foreach (rows[i]) begin
        apply(rows[i]);
        checks++;
        if (obs !== rows[i].exp || ret_obs !== CW'(ret_model)) begin
          errors++; $display("FAIL wrap jump %0d row %0d got %b/%0d need %b/%0d", k, i, obs, ret_obs, rows[i].exp, CW'(ret_model));
        end
        advance(rows[i]);
      end
    end
    #1;
    checks++;
    if (retired !== '0) begin
      errors++; $display("FAIL wrap_retired got %0d need 0", retired);
    end
    @(negedge clk);
    $display("test_wrap: 16 jumps");
  endtask

  task automatic test_reset_mid_mem();
    reset_dut();
    build(4'd5, 0, 0, 0, 0);
    foreach (rows[i]) begin
      apply(rows[i]);
      advance(rows[i]);
    end
    build(4'd4, 0, 0, 3, 0);
    for (int i = 0; i < 4; i++) begin
      apply(rows[i]);
      checks++;
      if (obs !== rows[i].exp) begin
        errors++; $display("FAIL sw_abort row %0d got %b need %b", i, obs, rows[i].exp);
      end
      if (i < 3) advance(rows[i]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || retired !== '0) begin
      errors++; $display("FAIL sw_abort_reset mem_req=%b mem_we=%b retired=%0d need 0 0 0", mem_req, mem_we, retired);
    end
    @(negedge clk);
    reset = 1'b0;
    ret_model = 0;
    build(4'd2, 0, 0, 0, 0);
    foreach (rows[i]) begin
      apply(rows[i]);
      checks++;
      if (obs !== rows[i].exp || ret_obs !== CW'(ret_model)) begin
        errors++; $display("FAIL after_abort row %0d got %b/%0d need %b/%0d", i, obs, ret_obs, rows[i].exp, CW'(ret_model));
      end
      advance(rows[i]);
    end
    $display("test_reset_mid_mem: SW abandoned, ADDI completes");
  endtask

  task automatic test_random();
    logic [3:0] op;
    int fw, mw;
    reset_dut();
    for (int k = 0; k < 60; k++) begin
      op = rop();
      fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(0, 5);
      mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(0, 5);
      build(op, $urandom_range(0, 2), fw, mw, 2);
      foreach (rows[i]) begin
        apply(rows[i]);
        checks++;
        if (obs !== rows[i].exp) begin
          errors++; $display("FAIL random instr %0d op %0d row %0d got %b need %b", k, op, i, obs, rows[i].exp);
        end
        checks++;
        if (ret_obs !== CW'(ret_model)) begin
          errors++; $display("FAIL random_ret instr %0d row %0d got %0d need %0d", k, i, ret_obs, CW'(ret_model));
        end
        advance(rows[i]);
      end
      $display("random instr %0d op=%0d fw=%0d mw=%0d halt=%0d retired=%0d", k, op, fw, mw, halts, CW'(ret_model));
      if (halts) reset_dut();
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 4'd0; ret_model = 0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_alu();
    test_lw_wait();
    test_jump();
    test_timeout();
    test_illegal();
    test_wrap();
    test_reset_mid_mem();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the bench ever stalls on the clock.
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
